hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-003 rs1_id, rs2_id  in  5 each  source register numbers of the instruction in ID.
REQ-004 uses_rs1_id, uses_rs2_id  in  1 each  ID instruction actually reads rs1/rs2.
REQ-005 rd_ex  in  5  destination register of the instruction in EX.
REQ-006 load_ex  in  1  EX instruction is a load.
REQ-007 jump_ex  in  1  taken jump/branch resolved in EX this cycle.
REQ-008 mem_req, mem_ack  in  1 each  MEM stage access pending / completed this cycle.
REQ-009 stall_if  out  1  hold PC.
REQ-010 stall_id  out  1  hold IF/ID register.
REQ-011 bubble_ex  out  1  load NOP (all-zero controls) into ID/EX.
REQ-012 stall_mem  out  1  freeze EX/MEM and MEM/WB registers.
REQ-013 nullify  out  1  kill the instruction in ID (zero ID/EX controls).
REQ-014 state  out  2  FSM state: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3.
REQ-015 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-016 hazard = load_ex & rd_ex!=0 & ((uses_rs1_id & rs1_id==rd_ex) | (uses_rs2_id & rs2_id==rd_ex)); register 0 never causes a hazard.
REQ-017 memwait = mem_req & !mem_ack.
REQ-018 Control outputs are combinational from state and inputs; state and counters are registered.
REQ-019 Priority in every state: memwait > jump_ex > hazard.
REQ-020 RUN, memwait: stall_if=stall_id=stall_mem=1, other controls 0; next MEM_WAIT.
REQ-021 RUN, jump_ex (no memwait): nullify=1, stalls 0; next FLUSH.
REQ-022 RUN, hazard (no memwait, no jump_ex): stall_if=stall_id=bubble_ex=1; next LOAD_STALL.
REQ-023 RUN, none: all controls 0; stay RUN.
REQ-024 LOAD_STALL: exactly one bubble per load-use; controls 0 unless memwait (REQ-020 rules, next MEM_WAIT) or jump_ex (REQ-021 rules); otherwise next RUN.
REQ-025 MEM_WAIT, memwait: stall_if=stall_id=stall_mem=1, jump_ex and hazard ignored; stay MEM_WAIT.
REQ-026 MEM_WAIT, mem_ack=1: evaluate RUN rules (REQ-020..023) in the same cycle; no extra dead cycle.
REQ-027 FLUSH, no memwait: nullify=1 (kills wrong-path fetch), stalls 0; next RUN; jump_ex and hazard ignored.
REQ-028 FLUSH, memwait: nullify=1 plus stall_if=stall_id=stall_mem=1; stay FLUSH until memwait clears.
REQ-029 stall_cnt +1 each cycle stall_if=1; flush_cnt +1 each cycle nullify=1; both saturate at 16'hFFFF, no wrap.

Reset
REQ-030 While reset=1: all control outputs 0; next state RUN; stall_cnt=flush_cnt=0 after the edge.
REQ-031 Reset asserted mid-MEM_WAIT or mid-FLUSH aborts the sequence; first cycle after reset deassertion is RUN with counters 0.

Verification
REQ-032 load_ex=1, rd_ex=5, rs2_id=5, uses_rs2_id=1 -> that cycle stall_if=stall_id=bubble_ex=1, next state 1, then RUN; stall_cnt=1.
REQ-033 Same as REQ-032 with rd_ex=0, or uses_rs2_id=0 -> no stall, state stays 0.
REQ-034 mem_req=1, mem_ack=0 for 3 cycles, then ack -> stall_mem high exactly 3 cycles, state 2 then 0, stall_cnt=3.
REQ-035 jump_ex=1 with simultaneous hazard -> nullify=1 two consecutive cycles, bubble_ex=0, states 0->3->0, flush_cnt=2.
REQ-036 Hold memwait 70000 cycles -> stall_cnt=16'hFFFF; reset pulse -> counters 0, state 0, all controls 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, MEM-stage wait and
// taken-jump flush sequencing, plus saturating stall/flush event counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        uses_rs1_id,
  input  logic        uses_rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        load_ex,
  input  logic        jump_ex,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        stall_mem,
  output logic        nullify,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   hazard;
  logic   memwait;

  // Register 0 is hardwired to zero, so a load targeting it can never be consumed.
  assign hazard = load_ex && (rd_ex != 5'd0) &&
                  ((uses_rs1_id && (rs1_id == rd_ex)) ||
                   (uses_rs2_id && (rs2_id == rd_ex)));

  assign memwait = mem_req && !mem_ack;

  assign state = state_q;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_mem = 1'b0;
    nullify   = 1'b0;
    state_d   = state_q;

    if (reset) begin
      state_d = RUN;
    end else begin
      case (state_q)
        // MEM_WAIT falls back onto the RUN rules the moment the ack arrives,
        // and while still waiting the memwait branch keeps it in MEM_WAIT.
        RUN, MEM_WAIT: begin
          if (memwait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_mem = 1'b1;
            state_d   = MEM_WAIT;
          end else if (jump_ex) begin
            nullify = 1'b1;
            state_d = FLUSH;
          end else if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = LOAD_STALL;
          end else begin
            state_d = RUN;
          end
        end

        // The bubble is already in EX; hazard is ignored so one load-use
        // costs exactly one bubble.
        LOAD_STALL: begin
          if (memwait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_mem = 1'b1;
            state_d   = MEM_WAIT;
          end else if (jump_ex) begin
            nullify = 1'b1;
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end

        FLUSH: begin
          nullify = 1'b1;
          if (memwait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_mem = 1'b1;
            state_d   = FLUSH;
          end else begin
            state_d = RUN;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      if (stall_if && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (nullify && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-by-cycle vector table fed
// through a scoreboard queue, plus hand sequences for MEM wait and saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        uses_rs1_id, uses_rs2_id, load_ex, jump_ex, mem_req, mem_ack;
  logic        stall_if, stall_id, bubble_ex, stall_mem, nullify;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .uses_rs1_id (uses_rs1_id),
    .uses_rs2_id (uses_rs2_id),
    .rd_ex       (rd_ex),
    .load_ex     (load_ex),
    .jump_ex     (jump_ex),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .stall_mem   (stall_mem),
    .nullify     (nullify),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  // ctrl = {stall_if, stall_id, bubble_ex, stall_mem, nullify}; st/sc/fc are
  // the registered values visible during the cycle, before its rising edge.
  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, ld, jmp, req, ack;
    logic [4:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] sc, fc;
  } vec_t;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11100;
  localparam logic [4:0] C_MW   = 5'b11010;
  localparam logic [4:0] C_NUL  = 5'b00001;
  localparam logic [4:0] C_NMW  = 5'b11011;

  vec_t vecs[28];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic u1, logic u2,
                              logic [4:0] rd, logic ld, logic j, logic rq, logic ak,
                              logic [4:0] ctrl, logic [1:0] st, logic [15:0] sc, logic [15:0] fc);
    vec_t v;
    v.rst = r; v.rs1 = a; v.rs2 = b; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.ld = ld; v.jmp = j; v.req = rq; v.ack = ak;
    v.ctrl = ctrl; v.st = st; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset       = v.rst;
    rs1_id      = v.rs1;
    rs2_id      = v.rs2;
    uses_rs1_id = v.u1;
    uses_rs2_id = v.u2;
    rd_ex       = v.rd;
    load_ex     = v.ld;
    jump_ex     = v.jmp;
    mem_req     = v.req;
    mem_ack     = v.ack;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0));
  endtask

  function automatic logic [4:0] ctrl_now();
    return {stall_if, stall_id, bubble_ex, stall_mem, nullify};
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t exp_v;
    int   mem_cycles;

    //           r rs1 rs2 u1 u2 rd ld j rq ak  ctrl    st sc  fc
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0,  0);
    vecs[1]  = mk(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, C_LU,   0, 0,  0); // load-use on rs2
    vecs[2]  = mk(0, 0, 5, 0, 1, 5, 1, 0, 0, 0, C_NONE, 1, 1,  0); // only one bubble
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 1,  0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, C_NONE, 0, 1,  0); // rd = x0
    vecs[5]  = mk(0, 0, 5, 0, 0, 5, 1, 0, 0, 0, C_NONE, 0, 1,  0); // rs2 not used
    vecs[6]  = mk(0, 7, 3, 1, 1, 7, 1, 0, 0, 0, C_LU,   0, 1,  0); // load-use on rs1
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NUL,  1, 2,  0); // jump in LOAD_STALL
    vecs[8]  = mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, C_NUL,  3, 2,  1); // FLUSH ignores jump/hazard
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0, 2,  2);
    vecs[10] = mk(0, 5, 0, 1, 0, 5, 1, 1, 1, 0, C_MW,   2, 3,  2); // memwait beats jump/hazard
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   2, 4,  2);
    vecs[12] = mk(0, 0, 9, 0, 1, 9, 1, 0, 1, 1, C_LU,   2, 5,  2); // ack + hazard same cycle
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   1, 6,  2); // memwait in LOAD_STALL
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_NUL,  2, 7,  2); // ack + jump
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NMW,  3, 7,  3); // FLUSH held by memwait
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NMW,  3, 8,  4);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NUL,  3, 9,  5);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 9,  6);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW,   0, 9,  6);
    vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_NONE, 2, 10, 6); // reset mid MEM_WAIT
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0,  0);
    vecs[22] = mk(0, 4, 0, 1, 0, 4, 1, 1, 0, 0, C_NUL,  0, 0,  0); // jump beats hazard
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NUL,  3, 0,  1);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0,  2);
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NUL,  0, 0,  2);
    vecs[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 3, 0,  3); // reset mid FLUSH
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0,  0);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL v%0d.scoreboard: queue empty", i);
      end else begin
        exp_v = sb.pop_front();
        check($sformatf("v%0d.ctrl", i),      32'(ctrl_now()), 32'(exp_v.ctrl));
        check($sformatf("v%0d.state", i),     32'(state),      32'(exp_v.st));
        check($sformatf("v%0d.stall_cnt", i), 32'(stall_cnt),  32'(exp_v.sc));
        check($sformatf("v%0d.flush_cnt", i), 32'(flush_cnt),  32'(exp_v.fc));
      end
      @(posedge clk); #1;
    end

    // Three cycles of memwait, then ack: stall_mem for exactly three cycles.
    idle_inputs();
    pulse_reset();
    mem_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      mem_req = 1'b1;
      mem_ack = (i == 3);
      @(negedge clk);
      if (stall_mem) mem_cycles++;
      check($sformatf("memseq.state%0d", i), 32'(state), (i == 0) ? 32'd0 : 32'd2);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    check("memseq.stall_mem_cycles", 32'(mem_cycles), 32'd3);
    check("memseq.stall_cnt", 32'(stall_cnt), 32'd3);
    check("memseq.state_end", 32'(state), 32'd0);
    @(posedge clk); #1;

    // Saturation: memwait held well past 2^16 cycles.
    pulse_reset();
    mem_req = 1'b1;
    mem_ack = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    check("sat.stall_cnt", 32'(stall_cnt), 32'hFFFF);
    check("sat.flush_cnt", 32'(flush_cnt), 32'd0);
    check("sat.state", 32'(state), 32'd2);
    check("sat.ctrl", 32'(ctrl_now()), 32'(C_MW));

    // Reset while memwait is still asserted.
    reset = 1'b1;
    @(negedge clk);
    check("sat.rst_ctrl", 32'(ctrl_now()), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("sat.post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("sat.post_rst_flush_cnt", 32'(flush_cnt), 32'd0);
    check("sat.post_rst_state", 32'(state), 32'd0);
    check("sat.post_rst_ctrl", 32'(ctrl_now()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
